// File: rtl/axi4_lite_pkg.sv
// Shared types and width helpers for the AXI4-Lite slave and its storage.
package axi4_lite_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } resp_t;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } wstate_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rstate_t;

    localparam int unsigned BYTE_LANES = 4;
    localparam int unsigned LANE_BITS  = 2;

    function automatic int unsigned index_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/axi4_lite_mem.sv
// Word-organised storage: one byte-enabled write port, one registered read port,
// contents and read register cleared asynchronously.
module axi4_lite_mem
    import axi4_lite_pkg::*;
#(
    parameter int unsigned DEPTH      = 64,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned IDX_W      = index_width(DEPTH)
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic                  wr_en,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic [BYTE_LANES-1:0] wr_strb,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [IDX_W-1:0]      rd_idx,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Read samples the array before this edge's write lands, so a same-edge
    // read of the written word returns the old contents.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[IDX_W'(i)] <= '0;
            end
            rd_data <= '0;
        end else begin
            if (wr_en) begin
                for (int unsigned b = 0; b < BYTE_LANES; b++) begin
                    if (wr_strb[b]) begin
                        mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                    end
                end
            end
            if (rd_en) begin
                rd_data <= mem[rd_idx];
            end
        end
    end

endmodule

// File: rtl/axi4_lite_slave.sv
// AXI4-Lite memory slave with independent write and read state machines.
module axi4_lite_slave
    import axi4_lite_pkg::*;
#(
    parameter int unsigned ADDRESS    = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 64
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic [ADDRESS-1:0]    S_AWADDR,
    input  logic                  S_AWVALID,
    output logic                  S_AWREADY,
    input  logic [DATA_WIDTH-1:0] S_WDATA,
    input  logic [3:0]            S_WSTRB,
    input  logic                  S_WVALID,
    output logic                  S_WREADY,
    output logic [1:0]            S_BRESP,
    output logic                  S_BVALID,
    input  logic                  S_BREADY,
    input  logic [ADDRESS-1:0]    S_ARADDR,
    input  logic                  S_ARVALID,
    output logic                  S_ARREADY,
    output logic [DATA_WIDTH-1:0] S_RDATA,
    output logic [1:0]            S_RRESP,
    output logic                  S_RVALID,
    input  logic                  S_RREADY
);

    localparam int unsigned       IDX_W      = index_width(DEPTH);
    localparam logic [ADDRESS-1:0] ADDR_LIMIT = ADDRESS'(DEPTH * 4);

    wstate_t w_state, w_state_nx;
    rstate_t r_state, r_state_nx;

    logic                  ready_en;
    logic                  aw_held, w_held;
    logic [ADDRESS-1:0]    awaddr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [3:0]            wstrb_q;
    resp_t                 bresp_q, rresp_q;

    logic                  aw_hs, w_hs, ar_hs, b_hs, commit;
    logic                  wr_in_range, rd_in_range;
    logic [ADDRESS-1:0]    wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [3:0]            wr_strb;
    logic [DATA_WIDTH-1:0] mem_rdata;

    always_comb begin
        w_state_nx = w_state;
        S_AWREADY  = 1'b0;
        S_WREADY   = 1'b0;
        S_BVALID   = 1'b0;
        commit     = 1'b0;
        unique case (w_state)
            W_IDLE: begin
                S_AWREADY = ready_en && !aw_held;
                S_WREADY  = ready_en && !w_held;
                commit    = (aw_held || (S_AWVALID && S_AWREADY)) &&
                            (w_held  || (S_WVALID  && S_WREADY));
                if (commit) w_state_nx = W_RESP;
            end
            W_RESP: begin
                S_BVALID = 1'b1;
                if (S_BREADY) w_state_nx = W_IDLE;
            end
        endcase
    end

    always_comb begin
        r_state_nx = r_state;
        S_ARREADY  = 1'b0;
        S_RVALID   = 1'b0;
        unique case (r_state)
            R_IDLE: begin
                S_ARREADY = ready_en;
                if (S_ARVALID && ready_en) r_state_nx = R_DATA;
            end
            R_DATA: begin
                S_RVALID = 1'b1;
                if (S_RREADY) r_state_nx = R_IDLE;
            end
        endcase
    end

    assign aw_hs = S_AWVALID && S_AWREADY;
    assign w_hs  = S_WVALID && S_WREADY;
    assign ar_hs = S_ARVALID && S_ARREADY;
    assign b_hs  = S_BVALID && S_BREADY;

    // A half that is not yet held must be handshaking on the commit edge,
    // so the live bus value stands in for it.
    assign wr_addr     = aw_held ? awaddr_q : S_AWADDR;
    assign wr_data     = w_held ? wdata_q : S_WDATA;
    assign wr_strb     = w_held ? wstrb_q : S_WSTRB;
    assign wr_in_range = wr_addr < ADDR_LIMIT;
    assign rd_in_range = S_ARADDR < ADDR_LIMIT;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            w_state  <= W_IDLE;
            r_state  <= R_IDLE;
            ready_en <= 1'b0;
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            awaddr_q <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            bresp_q  <= OKAY;
            rresp_q  <= OKAY;
        end else begin
            ready_en <= 1'b1;
            w_state  <= w_state_nx;
            r_state  <= r_state_nx;
            if (aw_hs) begin
                aw_held  <= 1'b1;
                awaddr_q <= S_AWADDR;
            end
            if (w_hs) begin
                w_held  <= 1'b1;
                wdata_q <= S_WDATA;
                wstrb_q <= S_WSTRB;
            end
            if (commit) bresp_q <= wr_in_range ? OKAY : SLVERR;
            if (b_hs) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
            end
            if (ar_hs) rresp_q <= rd_in_range ? OKAY : SLVERR;
        end
    end

    axi4_lite_mem #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_W      (IDX_W)
    ) u_mem (
        .ACLK    (ACLK),
        .ARESETN (ARESETN),
        .wr_en   (commit && wr_in_range),
        .wr_idx  (wr_addr[IDX_W+1:2]),
        .wr_strb (wr_strb),
        .wr_data (wr_data),
        .rd_en   (ar_hs && rd_in_range),
        .rd_idx  (S_ARADDR[IDX_W+1:2]),
        .rd_data (mem_rdata)
    );

    assign S_BRESP = bresp_q;
    assign S_RRESP = rresp_q;
    assign S_RDATA = (rresp_q == SLVERR) ? '0 : mem_rdata;

endmodule

// File: tb/tb_axi4_lite_slave.sv
// Scoreboard bench for axi4_lite_slave: expected responses queued at issue time.
`timescale 1ns/1ps
module tb_axi4_lite_slave;
    import axi4_lite_pkg::*;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned DEPTH = 64;

    logic          ACLK = 1'b0;
    logic          ARESETN = 1'b0;
    logic [AW-1:0] S_AWADDR = '0;
    logic          S_AWVALID = 1'b0;
    logic          S_AWREADY;
    logic [DW-1:0] S_WDATA = '0;
    logic [3:0]    S_WSTRB = '0;
    logic          S_WVALID = 1'b0;
    logic          S_WREADY;
    logic [1:0]    S_BRESP;
    logic          S_BVALID;
    logic          S_BREADY = 1'b0;
    logic [AW-1:0] S_ARADDR = '0;
    logic          S_ARVALID = 1'b0;
    logic          S_ARREADY;
    logic [DW-1:0] S_RDATA;
    logic [1:0]    S_RRESP;
    logic          S_RVALID;
    logic          S_RREADY = 1'b0;

    always #5 ACLK = ~ACLK;

    axi4_lite_slave #(.ADDRESS(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .S_AWADDR(S_AWADDR), .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY),
        .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB), .S_WVALID(S_WVALID), .S_WREADY(S_WREADY),
        .S_BRESP(S_BRESP), .S_BVALID(S_BVALID), .S_BREADY(S_BREADY),
        .S_ARADDR(S_ARADDR), .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
        .S_RDATA(S_RDATA), .S_RRESP(S_RRESP), .S_RVALID(S_RVALID), .S_RREADY(S_RREADY)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    logic [31:0] model [DEPTH];
    logic [1:0]  b_q [$];
    logic [33:0] r_q [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit in_range(input logic [31:0] addr);
        return addr < DEPTH * 4;
    endfunction

    function automatic int unsigned widx(input logic [31:0] addr);
        return (addr >> 2) % DEPTH;
    endfunction

    task automatic queue_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int unsigned idx;
        idx = widx(addr);
        if (in_range(addr)) begin
            b_q.push_back(OKAY);
            for (int b = 0; b < 4; b++)
                if (strb[b]) model[idx][8*b +: 8] = data[8*b +: 8];
        end else begin
            b_q.push_back(SLVERR);
        end
    endtask

    task automatic queue_read(input logic [31:0] addr);
        if (in_range(addr)) r_q.push_back({OKAY, model[widx(addr)]});
        else                r_q.push_back({SLVERR, 32'h0});
    endtask

    // Drives whatever VALIDs are raised until each sees READY; entered and left at a negedge.
    task automatic drive_hs(input string tag);
        logic aw_r, w_r, ar_r;
        int c;
        c = 0;
        while ((S_AWVALID || S_WVALID || S_ARVALID) && c < 20) begin
            aw_r = S_AWREADY; w_r = S_WREADY; ar_r = S_ARREADY;
            @(posedge ACLK);
            @(negedge ACLK);
            if (aw_r) S_AWVALID = 1'b0;
            if (w_r)  S_WVALID  = 1'b0;
            if (ar_r) S_ARVALID = 1'b0;
            c++;
        end
        if (S_AWVALID || S_WVALID || S_ARVALID) begin
            chk({tag, "_hs_timeout"}, 1, 0);
            S_AWVALID = 1'b0; S_WVALID = 1'b0; S_ARVALID = 1'b0;
        end
    endtask

    task automatic collect_b(input int hold);
        logic [1:0] exp;
        int c;
        exp = OKAY;
        c = 0;
        while (!S_BVALID && c < 20) begin @(negedge ACLK); c++; end
        chk("b_valid_wait", S_BVALID, 1);
        if (b_q.size() == 0) chk("b_sb_empty", 1, 0);
        else begin exp = b_q.pop_front(); chk("bresp", S_BRESP, exp); end
        for (int i = 0; i < hold; i++) begin
            @(negedge ACLK);
            chk("b_hold_valid", S_BVALID, 1);
            chk("b_hold_resp", S_BRESP, exp);
            chk("b_hold_ready", {S_AWREADY, S_WREADY}, 0);
        end
        S_BREADY = 1'b1;
        @(negedge ACLK);
        S_BREADY = 1'b0;
        chk("b_done", S_BVALID, 0);
    endtask

    task automatic collect_r(input int hold);
        logic [33:0] exp;
        int c;
        exp = '0;
        c = 0;
        while (!S_RVALID && c < 20) begin @(negedge ACLK); c++; end
        chk("r_valid_wait", S_RVALID, 1);
        if (r_q.size() == 0) chk("r_sb_empty", 1, 0);
        else begin exp = r_q.pop_front(); chk("rresp_rdata", {S_RRESP, S_RDATA}, exp); end
        for (int i = 0; i < hold; i++) begin
            @(negedge ACLK);
            chk("r_hold_valid", S_RVALID, 1);
            chk("r_hold_payload", {S_RRESP, S_RDATA}, exp);
            chk("r_hold_ready", S_ARREADY, 0);
        end
        S_RREADY = 1'b1;
        @(negedge ACLK);
        S_RREADY = 1'b0;
        chk("r_done", S_RVALID, 0);
    endtask

    // lead > 0: W leads AW by lead cycles; lead < 0: AW leads W; 0: same cycle.
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int lead, input int hold);
        queue_write(addr, data, strb);
        S_AWADDR = addr; S_WDATA = data; S_WSTRB = strb;
        if (lead == 0) begin
            S_AWVALID = 1'b1; S_WVALID = 1'b1;
            drive_hs("aw_w");
            chk("b_latency", S_BVALID, 1);
        end else if (lead > 0) begin
            S_WVALID = 1'b1;
            drive_hs("w");
            repeat (lead - 1) @(negedge ACLK);
            chk("b_early_w", S_BVALID, 0);
            S_AWVALID = 1'b1;
            drive_hs("aw");
        end else begin
            S_AWVALID = 1'b1;
            drive_hs("aw");
            repeat (-lead - 1) @(negedge ACLK);
            chk("b_early_aw", S_BVALID, 0);
            S_WVALID = 1'b1;
            drive_hs("w");
        end
        collect_b(hold);
    endtask

    task automatic axi_read(input logic [31:0] addr, input int hold);
        queue_read(addr);
        S_ARADDR = addr;
        S_ARVALID = 1'b1;
        drive_hs("ar");
        chk("r_latency", S_RVALID, 1);
        collect_r(hold);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) model[i] = '0;

        @(negedge ACLK);
        chk("rst_ready", {S_AWREADY, S_WREADY, S_ARREADY}, 0);
        chk("rst_valid", {S_BVALID, S_RVALID}, 0);
        chk("rst_payload", {S_BRESP, S_RRESP, S_RDATA}, 0);
        ARESETN = 1'b1;
        #1 chk("rel_ready_pre_edge", {S_AWREADY, S_WREADY, S_ARREADY}, 0);
        @(negedge ACLK);
        chk("rel_ready_post_edge", {S_AWREADY, S_WREADY, S_ARREADY}, 3'b111);

        axi_write(32'h10, 32'hDEADBEEF, 4'hF, 0, 0);
        axi_read(32'h10, 0);
        axi_write(32'h10, 32'h12345678, 4'b0011, 3, 0);
        axi_read(32'h10, 0);
        axi_read(32'h13, 0);

        axi_write(32'h100, 32'hCAFEF00D, 4'hF, 0, 0);
        axi_read(32'h0, 0);
        axi_read(32'h100, 0);

        axi_write(32'h10, 32'hFFFFFFFF, 4'h0, 0, 0);
        axi_read(32'h10, 0);
        axi_write(32'h24, 32'h11223344, 4'b1100, -2, 0);
        axi_read(32'h24, 0);

        axi_write(32'h30, 32'h0BADF00D, 4'hF, 0, 5);
        axi_read(32'h30, 5);

        // Write commit and read of the same word on one edge.
        S_AWADDR = 32'h20; S_WDATA = 32'hA5A5A5A5; S_WSTRB = 4'hF; S_ARADDR = 32'h20;
        queue_read(32'h20);
        queue_write(32'h20, 32'hA5A5A5A5, 4'hF);
        S_AWVALID = 1'b1; S_WVALID = 1'b1; S_ARVALID = 1'b1;
        drive_hs("aw_w_ar");
        collect_b(0);
        collect_r(0);
        axi_read(32'h20, 0);

        // Back-to-back reads with ARVALID and RREADY held high.
        S_ARADDR = 32'h10; S_ARVALID = 1'b1; S_RREADY = 1'b1;
        for (int i = 0; i < 3; i++) queue_read(32'h10);
        for (int i = 0; i < 6; i++) begin
            @(negedge ACLK);
            chk("b2b_rvalid", S_RVALID, (i % 2 == 0) ? 1 : 0);
            if (S_RVALID) begin
                if (r_q.size() == 0) chk("b2b_sb_empty", 1, 0);
                else chk("b2b_rdata", {S_RRESP, S_RDATA}, r_q.pop_front());
            end
        end
        S_ARVALID = 1'b0; S_RREADY = 1'b0;
        chk("b2b_sb_drained", r_q.size(), 0);

        // Reset with both channels holding responses.
        S_AWADDR = 32'h10; S_WDATA = 32'h55AA55AA; S_WSTRB = 4'hF; S_ARADDR = 32'h24;
        S_AWVALID = 1'b1; S_WVALID = 1'b1; S_ARVALID = 1'b1;
        drive_hs("rst_txn");
        chk("pre_rst_valids", {S_BVALID, S_RVALID}, 2'b11);
        #2 ARESETN = 1'b0;
        #1;
        chk("mid_rst_valids", {S_BVALID, S_RVALID}, 0);
        chk("mid_rst_ready", {S_AWREADY, S_WREADY, S_ARREADY}, 0);
        chk("mid_rst_payload", {S_BRESP, S_RRESP, S_RDATA}, 0);
        b_q.delete(); r_q.delete();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        @(negedge ACLK);
        ARESETN = 1'b1;
        @(negedge ACLK);
        chk("post_rst_ready", {S_AWREADY, S_WREADY, S_ARREADY}, 3'b111);
        chk("post_rst_no_b", S_BVALID, 0);
        axi_read(32'h10, 0);
        axi_read(32'h20, 0);
        axi_read(32'h24, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
